tetris_move_sequencer: RTL
==========================

TETRIS_MOVE_SEQUENCER -- requirements
Module: tetris_move_sequencer

Interface
REQ-001 SHALL have parameter SPAWN_X, default 4'd7: spawn column.
REQ-002 SHALL have parameter SPAWN_Y, default 5'd0: spawn row.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port spawn_valid  input  1: spawn request.
REQ-006 SHALL have port spawn_type  input  3: piece_type_t to spawn.
REQ-007 SHALL have port spawn_ready  output  1: high when a spawn is accepted this cycle.
REQ-008 SHALL have port cmd_valid  input  1: player command request.
REQ-009 SHALL have port cmd  input  2: command_t encoding (0 soft drop, 1 rotate, 2 left, 3 right).
REQ-010 SHALL have port cmd_ready  output  1: high when a command is accepted this cycle.
REQ-011 SHALL have port gravity_tick  input  1: one-cycle gravity pulse.
REQ-012 SHALL have port chk_req  output  1: collision-check request to the board.
REQ-013 SHALL have port chk_piece  output  14: candidate active_piece_t {type, rotation, x, y}.
REQ-014 SHALL have port chk_ack  input  1: checker result valid.
REQ-015 SHALL have port chk_collide  input  1: candidate collides; sampled only when chk_ack=1.
REQ-016 SHALL have port active_piece  output  14: committed active_piece_t.
REQ-017 SHALL have port piece_valid  output  1: active_piece holds a live piece.
REQ-018 SHALL have port lock_pulse  output  1: one-cycle strobe; board merges active_piece.
REQ-019 SHALL have port game_over  output  1: sticky spawn-collision flag.

Function
REQ-020 SHALL implement states IDLE, SPAWN_CHK, ACTIVE, MOVE_CHK, LOCK.
REQ-021 SHALL drive spawn_ready=1 only in IDLE with game_over=0; spawn_valid&spawn_ready builds candidate {spawn_type, ROT_0, SPAWN_X, SPAWN_Y} and enters SPAWN_CHK.
REQ-022 SHALL, in SPAWN_CHK, on chk_ack with chk_collide=0: commit candidate, set piece_valid, enter ACTIVE; with chk_collide=1: set game_over, return to IDLE, piece_valid stays 0.
REQ-023 SHALL latch gravity_tick into a 1-bit pending flag in any state while piece_valid=1; ticks arriving while pending is set are dropped; ticks with piece_valid=0 are ignored.
REQ-024 SHALL, in ACTIVE, service pending gravity first (candidate y+1, clear pending); otherwise drive cmd_ready=1 and accept cmd; cmd_ready=0 in all other states and whenever pending=1 or a gravity_tick is present this cycle.
REQ-025 SHALL form candidates: left x-1, right x+1, rotate rotation+1 mod 4, soft drop/gravity y+1; piece_type unchanged.
REQ-026 SHALL reject locally without chk_req: left at x=0, right at x=15, down at y=31; local rejection is handled as chk_collide=1 in the cycle after acceptance.
REQ-027 SHALL assert chk_req the cycle after a request is accepted, hold chk_req and chk_piece stable until the chk_ack cycle, and deassert chk_req the following cycle; chk_ack with chk_req=0 is ignored.
REQ-028 SHALL, on MOVE_CHK ack with collide=0, update active_piece in the next cycle and return to ACTIVE.
REQ-029 SHALL, on collide=1 for left/right/rotate, discard the candidate and return to ACTIVE unchanged.
REQ-030 SHALL, on collide=1 for gravity/soft drop, enter LOCK: lock_pulse=1 for exactly one cycle, piece_valid=0 and pending cleared in the same cycle, then IDLE; active_piece holds its last value.
REQ-031 SHALL keep game_over set until reset; with game_over=1 all requests are ignored.

Reset
REQ-032 SHALL, on reset asserted at any time including mid-check, immediately force IDLE, pending=0, chk_req=0, chk_piece=0, active_piece=0, piece_valid=0, lock_pulse=0, game_over=0, cmd_ready=0; spawn_ready=1 the first cycle after release.

Verification
REQ-033 SHALL verify spawn PIECE_T, ack collide=0 after 2 cycles -> chk_piece={T,ROT_0,7,0}, piece_valid=1, active_piece={T,ROT_0,7,0}.
REQ-034 SHALL verify cmd=LEFT at x=0 -> no chk_req, active_piece unchanged, cmd_ready=1 again within 2 cycles.
REQ-035 SHALL verify gravity_tick and cmd=RIGHT in the same cycle at {I,ROT_0,5,3} -> cmd_ready=0, chk_piece={I,ROT_0,5,4}; after ack, RIGHT accepted, yielding x=6.
REQ-036 SHALL verify gravity at y=18 with collide=1 -> single lock_pulse, piece_valid=0, active_piece y=18, spawn_ready=1 next.
REQ-037 SHALL verify spawn collide=1 -> game_over=1, spawn_ready=0, commands and ticks ignored until reset.
REQ-038 SHALL verify reset asserted while chk_req=1 -> chk_req=0 asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/tetris_move_sequencer.sv
// tetris_move_sequencer: spawns the active piece, sequences moves/gravity through an external collision check, and locks it.
//   clk, reset (async, active-high)
//   spawn_valid/spawn_type/spawn_ready : spawn handshake
//   cmd_valid/cmd/cmd_ready            : player command handshake (0 drop, 1 rotate, 2 left, 3 right)
//   gravity_tick                       : one-cycle gravity pulse
//   chk_req/chk_piece/chk_ack/chk_collide : board collision-check handshake
//   active_piece/piece_valid/lock_pulse/game_over : committed piece and status
// Piece word layout: {type[2:0], rotation[1:0], x[3:0], y[4:0]}.
module tetris_move_sequencer #(
  parameter logic [3:0] SPAWN_X = 4'd7,
  parameter logic [4:0] SPAWN_Y = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spawn_valid,
  input  logic [2:0]  spawn_type,
  output logic        spawn_ready,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  output logic        cmd_ready,
  input  logic        gravity_tick,
  output logic        chk_req,
  output logic [13:0] chk_piece,
  input  logic        chk_ack,
  input  logic        chk_collide,
  output logic [13:0] active_piece,
  output logic        piece_valid,
  output logic        lock_pulse,
  output logic        game_over
);
  typedef enum logic [2:0] {IDLE, SPAWN_CHK, ACTIVE, MOVE_CHK, LOCK} state_t;
  state_t state_q, state_d;
  logic pending_q, pending_d, chk_req_q, chk_req_d, valid_q, valid_d;
  logic over_q, over_d, down_q, down_d, rej_q, rej_d;
  logic [13:0] cand_q, cand_d, act_q, act_d;
  logic [2:0] t;
  logic [1:0] r, op;
  logic [3:0] x;
  logic [4:0] y;
  logic grav_fire, cmd_fire, spawn_fire, done, collide, mv_rej;
  logic [13:0] mv_cand;
  always_comb begin
    {t, r, x, y} = act_q;
    spawn_ready = state_q == IDLE && !over_q;
    cmd_ready = state_q == ACTIVE && !pending_q && !gravity_tick;
    grav_fire = state_q == ACTIVE && pending_q;
    cmd_fire = cmd_ready && cmd_valid;
    spawn_fire = spawn_ready && spawn_valid;
    // A locally rejected move completes as a collision without ever raising chk_req.
    done = rej_q || (chk_req_q && chk_ack);
    collide = rej_q || chk_collide;
    op = grav_fire ? 2'd0 : cmd;
    mv_cand = op == 2'd1 ? {t, r + 2'd1, x, y} :
              op == 2'd2 ? {t, r, x - 4'd1, y} :
              op == 2'd3 ? {t, r, x + 4'd1, y} : {t, r, x, y + 5'd1};
    mv_rej = op == 2'd2 ? x == 4'd0 : op == 2'd3 ? x == 4'hF : op == 2'd0 ? y == 5'h1F : 1'b0;
  end
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    chk_req_d = chk_req_q && !chk_ack;
    valid_d = valid_q;
    over_d = over_q;
    down_d = down_q;
    rej_d = 1'b0;
    cand_d = cand_q;
    act_d = act_q;
    // Only one gravity step can be outstanding; extra ticks are dropped.
    if (valid_q && gravity_tick && !pending_q) pending_d = 1'b1;
    case (state_q)
      IDLE: if (spawn_fire) begin
        cand_d = {spawn_type, 2'd0, SPAWN_X, SPAWN_Y};
        chk_req_d = 1'b1;
        state_d = SPAWN_CHK;
      end
      SPAWN_CHK: if (done) begin
        state_d = collide ? IDLE : ACTIVE;
        over_d = collide;
        valid_d = !collide;
        act_d = collide ? act_q : cand_q;
      end
      ACTIVE: if (grav_fire || cmd_fire) begin
        cand_d = mv_cand;
        chk_req_d = !mv_rej;
        rej_d = mv_rej;
        down_d = op == 2'd0;
        pending_d = grav_fire ? 1'b0 : pending_d;
        state_d = MOVE_CHK;
      end
      MOVE_CHK: if (done) begin
        act_d = collide ? act_q : cand_q;
        state_d = collide && down_q ? LOCK : ACTIVE;
        valid_d = !(collide && down_q);
        pending_d = collide && down_q ? 1'b0 : pending_d;
      end
      LOCK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      chk_req_q <= 1'b0;
      valid_q <= 1'b0;
      over_q <= 1'b0;
      down_q <= 1'b0;
      rej_q <= 1'b0;
      cand_q <= '0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      chk_req_q <= chk_req_d;
      valid_q <= valid_d;
      over_q <= over_d;
      down_q <= down_d;
      rej_q <= rej_d;
      cand_q <= cand_d;
      act_q <= act_d;
    end
  end
  assign chk_req = chk_req_q;
  assign chk_piece = cand_q;
  assign active_piece = act_q;
  assign piece_valid = valid_q;
  assign lock_pulse = state_q == LOCK;
  assign game_over = over_q;
endmodule
